// File: rtl/wdc_port_target.sv
// Device-side responder for the WD33C93 port: register and DMA cycles on PD,
// an 8-byte FIFO, and a byte-stream source/sink standing in for the SCSI bus.
module wdc_port_target #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       SCLK,
  input  logic       _RST,
  input  logic       _CSS,
  input  logic       _IOR,
  input  logic       _IOW,
  input  logic       _DACK,
  input  logic       A0,
  input  logic [7:0] PD_IN,
  output logic [7:0] PD_OUT,
  output logic       PD_OE,
  output logic       _DREQ,
  output logic       INTA,
  input  logic [7:0] SRC_DATA,
  input  logic       SRC_VALID,
  output logic       SRC_READY,
  output logic [7:0] SNK_DATA,
  output logic       SNK_VALID
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, XIN = 2'd1, XOUT = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [23:0] sat_dec24(input logic [23:0] v, input logic en);
    sat_dec24 = (en && v != 24'd0) ? v - 24'd1 : v;
  endfunction

  logic css_p0, ior_p0, iow_p0, dack_p0, a0_p0;
  logic dma_sel, reg_sel, rd_act, wr_act;
  logic rd_pend_p1, wr_pend_p1, acc_dma_p1, acc_a0_p1;
  logic [7:0] wdata_p1, pd_out_p1, rd_data, fifo_rd_byte, aux_stat;
  logic rd_commit, wr_commit, aux_wr, reg_rd_c, reg_wr_c, data_rd, data_wr;
  logic cmd_wr, st_rd, addr_inc, scratch_wr;
  logic start_in, start_out, abort, flush, done_evt;
  logic src_ready, src_push, host_pop, host_push, snk_pop, push, pop, tc_dec;
  logic empty, full, bsy, dbr, dreq_ok;
  logic [CW-1:0] wr_ptr, rd_ptr, count, cnt_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] scratch [32];
  logic [4:0] addr;
  logic [23:0] tc, tc_nxt, scnt;
  logic [7:0] status;
  logic int_q, dreq_n_q, snk_valid_q;
  logic [7:0] snk_data_q;
  state_t state, state_nxt;

  // Stage p0: strobes, selects and A0 registered once
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      css_p0  <= 1'b1;
      ior_p0  <= 1'b1;
      iow_p0  <= 1'b1;
      dack_p0 <= 1'b1;
      a0_p0   <= 1'b0;
    end else begin
      css_p0  <= _CSS;
      ior_p0  <= _IOR;
      iow_p0  <= _IOW;
      dack_p0 <= _DACK;
      a0_p0   <= A0;
    end
  end

  assign dma_sel = ~dack_p0;
  assign reg_sel = dack_p0 & ~css_p0;
  assign rd_act  = ~ior_p0 & (dma_sel | reg_sel);
  assign wr_act  = ~iow_p0 & (dma_sel | reg_sel);

  // Stage p1: access tracking, write data capture and read data register
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      rd_pend_p1 <= 1'b0;
      wr_pend_p1 <= 1'b0;
      acc_dma_p1 <= 1'b0;
      acc_a0_p1  <= 1'b0;
      pd_out_p1  <= 8'h00;
    end else begin
      rd_pend_p1 <= rd_act;
      wr_pend_p1 <= wr_act;
      if (rd_act || wr_act) begin
        acc_dma_p1 <= dma_sel;
        acc_a0_p1  <= a0_p0;
      end
      pd_out_p1 <= rd_act ? rd_data : 8'h00;
    end
  end

  always_ff @(posedge SCLK) begin
    if (wr_act) wdata_p1 <= PD_IN;
  end

  // Side effects fire on the sampled rising edge of the strobe
  assign rd_commit  = rd_pend_p1 & ior_p0;
  assign wr_commit  = wr_pend_p1 & iow_p0;
  assign aux_wr     = wr_commit & ~acc_dma_p1 & ~acc_a0_p1;
  assign reg_rd_c   = rd_commit & ~acc_dma_p1 & acc_a0_p1;
  assign reg_wr_c   = wr_commit & ~acc_dma_p1 & acc_a0_p1;
  assign data_rd    = (rd_commit & acc_dma_p1) | (reg_rd_c & (addr == 5'h19));
  assign data_wr    = (wr_commit & acc_dma_p1) | (reg_wr_c & (addr == 5'h19));
  assign cmd_wr     = reg_wr_c & (addr == 5'h18);
  assign st_rd      = reg_rd_c & (addr == 5'h17);
  assign addr_inc   = (reg_rd_c | reg_wr_c) & (addr != 5'h18) & (addr != 5'h19);
  assign scratch_wr = reg_wr_c & ~(addr inside {5'h12, 5'h13, 5'h14, 5'h17, 5'h18, 5'h19});

  assign start_in  = cmd_wr & (state == IDLE) & (wdata_p1 == 8'h20);
  assign start_out = cmd_wr & (state == IDLE) & (wdata_p1 == 8'h21);
  assign abort     = cmd_wr & (wdata_p1 == 8'h00);
  assign flush     = start_in | start_out | abort;
  assign done_evt  = (state == DONE) & ~abort;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  assign src_ready = (state == XIN) & ~full & (scnt != 24'd0);
  assign src_push  = SRC_VALID & src_ready;
  assign host_pop  = (state == XIN) & data_rd & ~empty;
  assign host_push = (state == XOUT) & data_wr & ~full;
  assign snk_pop   = (state == XOUT) & ~empty;
  assign push      = src_push | host_push;
  assign pop       = host_pop | snk_pop;
  assign tc_dec    = host_pop | host_push;
  assign tc_nxt    = sat_dec24(tc, tc_dec);
  assign cnt_nxt   = flush ? '0 : count + CW'(push) - CW'(pop);

  assign bsy          = (state == XIN) | (state == XOUT);
  assign dbr          = ((state == XIN) & ~empty) | ((state == XOUT) & ~full);
  assign aux_stat     = {int_q, 1'b0, bsy, 4'b0000, dbr};
  assign fifo_rd_byte = ((state == XIN) && !empty) ? mem[rd_ptr[PW-1:0]] : 8'h00;

  always_comb begin
    rd_data = 8'h00;
    if (dma_sel) begin
      rd_data = fifo_rd_byte;
    end else if (!a0_p0) begin
      rd_data = aux_stat;
    end else begin
      case (addr)
        5'h12:   rd_data = tc[23:16];
        5'h13:   rd_data = tc[15:8];
        5'h14:   rd_data = tc[7:0];
        5'h17:   rd_data = status;
        5'h18:   rd_data = 8'h00;
        5'h19:   rd_data = fifo_rd_byte;
        default: rd_data = scratch[addr];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = XIN;
        else if (start_out) state_nxt = XOUT;
      end
      XIN:     if (tc_nxt == 24'd0) state_nxt = DONE;
      XOUT:    if (tc_nxt == 24'd0 && cnt_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // A last-byte decrement or abort on this edge must already hold _DREQ high
  assign dreq_ok = dbr & dack_p0 & (tc_nxt != 24'd0) & (state_nxt == state);

  // Stage p2: control state, counters, status and stream outputs
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state       <= IDLE;
      addr        <= 5'd0;
      tc          <= 24'd0;
      scnt        <= 24'd0;
      status      <= 8'h00;
      int_q       <= 1'b0;
      dreq_n_q    <= 1'b1;
      snk_valid_q <= 1'b0;
      snk_data_q  <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (aux_wr) addr <= wdata_p1[4:0];
      else if (addr_inc) addr <= addr + 5'd1;

      if (reg_wr_c && addr == 5'h12) tc[23:16] <= wdata_p1;
      else if (reg_wr_c && addr == 5'h13) tc[15:8] <= wdata_p1;
      else if (reg_wr_c && addr == 5'h14) tc[7:0] <= wdata_p1;
      else tc <= tc_nxt;

      if (start_in || start_out) scnt <= tc;
      else scnt <= sat_dec24(scnt, src_push);

      if (abort) begin
        status <= 8'h22;
        int_q  <= 1'b1;
      end else if (done_evt) begin
        status <= 8'h16;
        int_q  <= 1'b1;
      end else if (st_rd) begin
        int_q  <= 1'b0;
      end

      dreq_n_q    <= ~dreq_ok;
      snk_valid_q <= snk_pop & ~abort;
      if (snk_pop) snk_data_q <= mem[rd_ptr[PW-1:0]];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + CW'(1);
        if (pop) rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (push && !flush) mem[wr_ptr[PW-1:0]] <= (state == XIN) ? SRC_DATA : wdata_p1;
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      for (int i = 0; i < 32; i++) scratch[i] <= 8'h00;
    end else if (scratch_wr) begin
      scratch[addr] <= wdata_p1;
    end
  end

  assign PD_OUT    = pd_out_p1;
  assign PD_OE     = rd_pend_p1;
  assign _DREQ     = dreq_n_q;
  assign INTA      = int_q;
  assign SRC_READY = src_ready;
  assign SNK_DATA  = snk_data_q;
  assign SNK_VALID = snk_valid_q;
endmodule

// File: tb/tb_wdc_port_target.sv
// Directed-sequence bench for wdc_port_target with random data bytes checked
// against a transaction-level model (byte queues, integer counters).
module tb_wdc_port_target;
  logic       sclk = 1'b0;
  logic       rst_n, css_n, ior_n, iow_n, dack_n, a0;
  logic [7:0] pd_in, pd_out, src_data, snk_data;
  logic       pd_oe, dreq_n, inta, src_valid, src_ready, snk_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_m[$];
  logic [7:0] exp_q[$];
  logic [7:0] snk_q[$];
  logic [7:0] regs_m [32];
  int         tc_m;

  wdc_port_target #(.FIFO_DEPTH(8)) dut (
    .SCLK(sclk), ._RST(rst_n), ._CSS(css_n), ._IOR(ior_n), ._IOW(iow_n),
    ._DACK(dack_n), .A0(a0), .PD_IN(pd_in), .PD_OUT(pd_out), .PD_OE(pd_oe),
    ._DREQ(dreq_n), .INTA(inta), .SRC_DATA(src_data), .SRC_VALID(src_valid),
    .SRC_READY(src_ready), .SNK_DATA(snk_data), .SNK_VALID(snk_valid)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (snk_valid === 1'b1) snk_q.push_back(snk_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #2;
  endtask

  task automatic reg_wr(input logic sel, input logic [7:0] d);
    a0 = sel; pd_in = d; css_n = 1'b0; iow_n = 1'b0;
    tick(2);
    iow_n = 1'b1;
    tick(1);
    css_n = 1'b1;
    tick(2);
  endtask

  task automatic reg_rd(input logic sel, output logic [7:0] d, output logic oe);
    a0 = sel; css_n = 1'b0; ior_n = 1'b0;
    tick(3);
    d = pd_out; oe = pd_oe;
    ior_n = 1'b1;
    tick(1);
    css_n = 1'b1;
    tick(2);
  endtask

  task automatic wait_dreq();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dreq_n === 1'b0) begin ok = 1'b1; break; end
      tick(1);
    end
    check("dreq_wait", ok, 1'b1);
  endtask

  task automatic dma_rd(output logic [7:0] d);
    wait_dreq();
    dack_n = 1'b0; ior_n = 1'b0;
    tick(3);
    d = pd_out;
    check("dreq_high_in_dack", dreq_n, 1'b1);
    ior_n = 1'b1;
    tick(1);
    dack_n = 1'b1;
    tick(2);
  endtask

  task automatic dma_wr(input logic [7:0] d);
    wait_dreq();
    dack_n = 1'b0; pd_in = d; iow_n = 1'b0;
    tick(2);
    iow_n = 1'b1;
    tick(1);
    dack_n = 1'b1;
    tick(2);
  endtask

  task automatic src_push(input logic [7:0] d);
    bit ok = 1'b0;
    src_data = d; src_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (src_ready === 1'b1) begin tick(1); ok = 1'b1; break; end
      tick(1);
    end
    src_valid = 1'b0;
    check("src_handshake", ok, 1'b1);
  endtask

  task automatic set_tc(input logic [23:0] v);
    reg_wr(1'b0, 8'h12);
    reg_wr(1'b1, v[23:16]);
    reg_wr(1'b1, v[15:8]);
    reg_wr(1'b1, v[7:0]);
    tc_m = int'(v);
  endtask

  task automatic command(input logic [7:0] c);
    reg_wr(1'b0, 8'h18);
    reg_wr(1'b1, c);
  endtask

  initial begin
    logic [7:0] r, r1, b, v0, v1;
    logic oe;
    int a;
    bit ok;

    rst_n = 1'b0; css_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1; dack_n = 1'b1;
    a0 = 1'b0; pd_in = 8'h00; src_data = 8'h00; src_valid = 1'b0;
    for (int i = 0; i < 32; i++) regs_m[i] = 8'h00;
    tick(3);
    check("rst_pd_out", pd_out, 8'h00);
    check("rst_pd_oe", pd_oe, 1'b0);
    check("rst_dreq", dreq_n, 1'b1);
    check("rst_inta", inta, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_snk_valid", snk_valid, 1'b0);
    check("rst_snk_data", snk_data, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // register access and auto-increment
    set_tc(24'h000100);
    b = 8'($urandom);
    reg_wr(1'b1, b);
    regs_m[5'h12 + 3] = b;
    reg_wr(1'b0, 8'h12);
    reg_rd(1'b1, r, oe);
    check("pd_oe_during_read", oe, 1'b1);
    check("tc_hi", r, 8'((tc_m >> 16) & 255));
    reg_rd(1'b1, r, oe);
    check("tc_mid", r, 8'((tc_m >> 8) & 255));
    reg_rd(1'b1, r, oe);
    check("tc_lo", r, 8'(tc_m & 255));
    check("pd_oe_after_read", pd_oe, 1'b0);
    reg_rd(1'b1, r, oe);
    check("addr_0x15_scratch", r, regs_m[5'h15]);
    reg_rd(1'b0, r, oe);
    check("aux_idle", r, 8'h00);

    for (int i = 0; i < 4; i++) begin
      a = int'($urandom_range(0, 21));
      if (a > 16) a = a - 17 + 26;
      v0 = 8'($urandom); v1 = 8'($urandom);
      reg_wr(1'b0, 8'(a));
      reg_wr(1'b1, v0);
      reg_wr(1'b1, v1);
      regs_m[a] = v0; regs_m[a + 1] = v1;
      reg_wr(1'b0, 8'(a));
      reg_rd(1'b1, r, oe);
      reg_rd(1'b1, r1, oe);
      check("scratch_a", r, regs_m[a]);
      check("scratch_a1", r1, regs_m[a + 1]);
    end

    // XFER_IN, TC=4
    set_tc(24'd4);
    command(8'h20);
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA1 : 8'($urandom);
      src_push(b);
      fifo_m.push_back(b);
    end
    tick(2);
    check("xin_dreq_low", dreq_n, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dma_rd(r);
      check("xin_dma_byte", r, fifo_m.pop_front());
      tc_m--;
    end
    check("xin_inta", inta, 1'b1);
    check("xin_dreq_done", dreq_n, 1'b1);
    reg_wr(1'b0, 8'h17);
    reg_rd(1'b1, r, oe);
    check("xin_status", r, 8'h16);
    check("xin_inta_cleared", inta, 1'b0);

    // XFER_OUT, TC=3
    snk_q.delete(); exp_q.delete();
    set_tc(24'd3);
    command(8'h21);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      dma_wr(b);
      exp_q.push_back(b);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (inta === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    check("xout_inta", ok, 1'b1);
    check("xout_snk_count", snk_q.size(), 3);
    for (int i = 0; i < 3 && i < snk_q.size(); i++) check("xout_snk_byte", snk_q[i], exp_q[i]);
    reg_wr(1'b0, 8'h17);
    reg_rd(1'b1, r, oe);
    check("xout_status", r, 8'h16);

    // FIFO boundaries, XFER_IN, TC=16
    fifo_m.delete();
    set_tc(24'd16);
    command(8'h20);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      src_push(b);
      fifo_m.push_back(b);
    end
    tick(2);
    check("full_src_ready", src_ready, 1'b0);
    reg_rd(1'b0, r, oe);
    check("full_aux", r, 8'h21);
    for (int i = 0; i < 8; i++) begin
      dma_rd(r);
      check("drain_byte", r, fifo_m.pop_front());
      tc_m--;
    end
    tick(2);
    check("empty_dreq_high", dreq_n, 1'b1);
    check("empty_src_ready", src_ready, 1'b1);
    reg_wr(1'b0, 8'h19);
    reg_rd(1'b1, r, oe);
    check("empty_read_zero", r, 8'h00);
    reg_wr(1'b0, 8'h12);
    reg_rd(1'b1, r, oe);
    reg_rd(1'b1, r1, oe);
    reg_rd(1'b1, b, oe);
    check("tc_after_empty_read", {8'h00, r, r1, b}, 32'(tc_m));
    command(8'h00);
    check("abort_in_inta", inta, 1'b1);
    check("abort_in_src_ready", src_ready, 1'b0);
    reg_wr(1'b0, 8'h17);
    reg_rd(1'b1, r, oe);
    check("abort_in_status", r, 8'h22);

    // ABORT mid XFER_OUT after 2 of 5
    snk_q.delete(); exp_q.delete();
    set_tc(24'd5);
    command(8'h21);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      dma_wr(b);
      exp_q.push_back(b);
    end
    tick(4);
    check("abort_out_snk_count", snk_q.size(), 2);
    for (int i = 0; i < 2 && i < snk_q.size(); i++) check("abort_out_snk_byte", snk_q[i], exp_q[i]);
    command(8'h00);
    check("abort_out_inta", inta, 1'b1);
    check("abort_out_dreq", dreq_n, 1'b1);
    reg_wr(1'b0, 8'h17);
    reg_rd(1'b1, r, oe);
    check("abort_out_status", r, 8'h22);
    command(8'h21);
    reg_rd(1'b0, r, oe);
    check("restart_aux", r, 8'h21);
    check("restart_snk_none", snk_q.size(), 2);

    // reset mid XFER_IN, then TC=0 start
    command(8'h00);
    set_tc(24'd5);
    command(8'h20);
    src_push(8'($urandom));
    src_push(8'($urandom));
    tick(2);
    check("pre_rst_dreq", dreq_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pd_out", pd_out, 8'h00);
    check("mid_rst_pd_oe", pd_oe, 1'b0);
    check("mid_rst_dreq", dreq_n, 1'b1);
    check("mid_rst_inta", inta, 1'b0);
    check("mid_rst_src_ready", src_ready, 1'b0);
    check("mid_rst_snk_valid", snk_valid, 1'b0);
    check("mid_rst_snk_data", snk_data, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    command(8'h20);
    check("tc0_inta_early", inta, 1'b0);
    tick(1);
    check("tc0_inta", inta, 1'b1);
    reg_wr(1'b0, 8'h17);
    reg_rd(1'b1, r, oe);
    check("tc0_status", r, 8'h16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
